fwd_hazard_unit: RTL and testbench

Parametrised forwarding and hazard unit for the 5-stage pipeline, replacing the purely combinational forwarding decode. It keeps its own three-slot record of in-flight destinations for EX, MEM and WB. From that record it produces registered per-operand forwarding selects for EX, the muxed EX operands, a load-use stall toward IF/ID, and a saturating stall counter. It sits between the ID/EX pipeline register and the ALU operand muxes.

---
 rtl/fwd_hazard_unit.sv | 111 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline.
// It tracks in-flight destinations in EX/MEM/WB and registers the per-operand EX forwarding selects.
module fwd_hazard_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [REG_AW-1:0]           id_dst,
  input  logic                        id_wr,
  input  logic                        id_is_load,
  input  logic                        ex_flush,
  input  logic [NUM_SRC*DATA_W-1:0]   ex_rf_data,
  input  logic [DATA_W-1:0]           mem_alu_data,
  input  logic [DATA_W-1:0]           wb_data,
  output logic                        id_stall,
  output logic [NUM_SRC*2-1:0]        ex_fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]   ex_opnd,
  output logic [CNT_W-1:0]            stall_cnt
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dst;
    logic              wr;
    logic              ld;
  } slot_t;

  slot_t                s0_q, s1_q, s2_q;
  slot_t                s0_d;
  logic [NUM_SRC-1:0]   hit0, hit1, hit2;
  logic [NUM_SRC*2-1:0] sel_d;
  logic [DATA_W-1:0]    wb_hold_q;
  logic                 issue;

  // Live matches of each ID operand against the three in-flight slots.
  always_comb begin
    hit0 = '0;
    hit1 = '0;
    hit2 = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_src_used[k] && (id_src[k*REG_AW +: REG_AW] != '0)) begin
        hit0[k] = s0_q.v && s0_q.wr && (s0_q.dst == id_src[k*REG_AW +: REG_AW]);
        hit1[k] = s1_q.v && s1_q.wr && (s1_q.dst == id_src[k*REG_AW +: REG_AW]);
        hit2[k] = s2_q.v && s2_q.wr && (s2_q.dst == id_src[k*REG_AW +: REG_AW]);
      end
    end
  end

  assign id_stall = id_valid && s0_q.ld && (|hit0);
  assign issue    = id_valid && !id_stall && !ex_flush;

  always_comb begin
    s0_d.v   = issue;
    s0_d.dst = id_dst;
    s0_d.wr  = id_wr;
    s0_d.ld  = id_is_load;
  end

  // Youngest producer wins; a load in S0 never forwards (that case stalls instead).
  always_comb begin
    sel_d = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (hit0[k] && !s0_q.ld) begin
        sel_d[2*k +: 2] = 2'd1;
      end else if (hit1[k]) begin
        sel_d[2*k +: 2] = 2'd2;
      end else if (hit2[k]) begin
        sel_d[2*k +: 2] = 2'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q       <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      ex_fwd_sel <= '0;
      wb_hold_q  <= '0;
      stall_cnt  <= '0;
    end else begin
      s0_q       <= s0_d;
      s1_q       <= s0_q;
      s2_q       <= s1_q;
      ex_fwd_sel <= issue ? sel_d : '0;
      wb_hold_q  <= wb_data;
      if (id_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    ex_opnd = ex_rf_data;
    for (int k = 0; k < NUM_SRC; k++) begin
      case (ex_fwd_sel[2*k +: 2])
        2'd1:    ex_opnd[k*DATA_W +: DATA_W] = mem_alu_data;
        2'd2:    ex_opnd[k*DATA_W +: DATA_W] = wb_data;
        2'd3:    ex_opnd[k*DATA_W +: DATA_W] = wb_hold_q;
        default: ex_opnd[k*DATA_W +: DATA_W] = ex_rf_data[k*DATA_W +: DATA_W];
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_fwd_hazard_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NS = 2;
  localparam int unsigned CW = 4;

  localparam logic [31:0] RF0 = 32'h1111_0000;
  localparam logic [31:0] RF1 = 32'h2222_0000;
  localparam logic [63:0] RF  = {RF1, RF0};

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic [NS*AW-1:0]  id_src;
  logic [NS-1:0]     id_src_used;
  logic [AW-1:0]     id_dst;
  logic              id_wr;
  logic              id_is_load;
  logic              ex_flush;
  logic [NS*DW-1:0]  ex_rf_data;
  logic [DW-1:0]     mem_alu_data;
  logic [DW-1:0]     wb_data;
  logic              id_stall;
  logic [NS*2-1:0]   ex_fwd_sel;
  logic [NS*DW-1:0]  ex_opnd;
  logic [CW-1:0]     stall_cnt;

  fwd_hazard_unit #(
    .DATA_W (DW),
    .REG_AW (AW),
    .NUM_SRC(NS),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_dst      (id_dst),
    .id_wr       (id_wr),
    .id_is_load  (id_is_load),
    .ex_flush    (ex_flush),
    .ex_rf_data  (ex_rf_data),
    .mem_alu_data(mem_alu_data),
    .wb_data     (wb_data),
    .id_stall    (id_stall),
    .ex_fwd_sel  (ex_fwd_sel),
    .ex_opnd     (ex_opnd),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        stall;
    logic [3:0]  sel;
    logic [63:0] opnd;
    logic [3:0]  cnt;
    bit          full;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input string field,
                     input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%0h required=%0h", name, field, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      cmp(mon_e.name, "id_stall", 64'(id_stall), 64'(mon_e.stall));
      cmp(mon_e.name, "stall_cnt", 64'(stall_cnt), 64'(mon_e.cnt));
      if (mon_e.full) begin
        cmp(mon_e.name, "ex_fwd_sel", 64'(ex_fwd_sel), 64'(mon_e.sel));
        cmp(mon_e.name, "ex_opnd", ex_opnd, mon_e.opnd);
      end
    end
  end

  task automatic push_exp(input string name, input logic stall, input logic [3:0] sel,
                          input logic [63:0] opnd, input logic [3:0] cnt, input bit full);
    exp_t e;
    e.name  = name;
    e.stall = stall;
    e.sel   = sel;
    e.opnd  = opnd;
    e.cnt   = cnt;
    e.full  = full;
    exp_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [1:0] used, input logic [4:0] dst, input logic wr,
                       input logic ld, input logic fl);
    id_valid     = v;
    id_src       = {a1, a0};
    id_src_used  = used;
    id_dst       = dst;
    id_wr        = wr;
    id_is_load   = ld;
    ex_flush     = fl;
    mem_alu_data = '0;
    wb_data      = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    ex_rf_data = RF;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0);
    cyc();
    push_exp("reset", 0, 4'h0, RF, 0, 1);
    cyc();
    rst = 1'b0;
    idle(2);

    // Back-to-back ALU dependency forwards from EX/MEM.
    cyc(); drive(1, 1, 2, 2'b11, 5, 1, 0, 0); push_exp("t1_prod", 0, 4'h0, RF, 0, 1);
    cyc(); drive(1, 5, 5, 2'b11, 6, 1, 0, 0); push_exp("t1_cons", 0, 4'h0, RF, 0, 1);
    cyc(); drive(0, 0, 0, 2'b00, 0, 0, 0, 0); mem_alu_data = 32'hA5;
    push_exp("t1_ex", 0, 4'b0101, {32'hA5, 32'hA5}, 0, 1);
    cyc(); drive(0, 0, 0, 2'b00, 0, 0, 0, 0); push_exp("t1_after", 0, 4'h0, RF, 0, 1);
    idle(3);

    // Load-use: one stall, then select 2 picks up the load data.
    cyc(); drive(1, 1, 0, 2'b01, 7, 1, 1, 0); push_exp("t2_lw", 0, 4'h0, RF, 0, 1);
    cyc(); drive(1, 7, 0, 2'b11, 8, 1, 0, 0); push_exp("t2_stall", 1, 4'h0, RF, 0, 1);
    cyc(); drive(1, 7, 0, 2'b11, 8, 1, 0, 0); push_exp("t2_issue", 0, 4'h0, RF, 1, 1);
    cyc(); drive(0, 0, 0, 2'b00, 0, 0, 0, 0); wb_data = 32'h1234;
    push_exp("t2_ex", 0, 4'b0010, {RF1, 32'h1234}, 1, 1);
    idle(4);

    // Producer three ahead: value comes from wb_hold.
    cyc(); drive(1, 1, 2, 2'b11, 3, 1, 0, 0); push_exp("t3_prod", 0, 4'h0, RF, 1, 1);
    cyc(); drive(1, 1, 2, 2'b11, 10, 1, 0, 0);
    cyc(); drive(1, 1, 2, 2'b11, 11, 1, 0, 0);
    cyc(); drive(1, 3, 3, 2'b11, 12, 1, 0, 0); wb_data = 32'h77;
    push_exp("t3_issue", 0, 4'h0, RF, 1, 1);
    cyc(); drive(0, 0, 0, 2'b00, 0, 0, 0, 0); wb_data = 32'h99;
    push_exp("t3_ex", 0, 4'b1111, {32'h77, 32'h77}, 1, 1);
    idle(3);

    // r0 is never forwarded and never stalls, even from a load.
    cyc(); drive(1, 1, 2, 2'b11, 0, 1, 1, 0); push_exp("t4_lw0", 0, 4'h0, RF, 1, 1);
    cyc(); drive(1, 0, 0, 2'b11, 14, 1, 0, 0); push_exp("t4_cons", 0, 4'h0, RF, 1, 1);
    cyc(); drive(0, 0, 0, 2'b00, 0, 0, 0, 0); mem_alu_data = 32'hA5; wb_data = 32'h99;
    push_exp("t4_ex", 0, 4'h0, RF, 1, 1);
    idle(3);

    // Stall and flush together: bubble, stall still counted.
    cyc(); drive(1, 1, 2, 2'b11, 7, 1, 1, 0); push_exp("t5_lw", 0, 4'h0, RF, 1, 1);
    cyc(); drive(1, 7, 7, 2'b11, 9, 1, 0, 1); push_exp("t5_stfl", 1, 4'h0, RF, 1, 1);
    cyc(); drive(1, 9, 7, 2'b11, 13, 1, 0, 0); push_exp("t5_next", 0, 4'h0, RF, 2, 1);
    cyc(); drive(0, 0, 0, 2'b00, 0, 0, 0, 0); wb_data = 32'h55;
    push_exp("t5_ex", 0, 4'b1000, {32'h55, RF0}, 2, 1);
    idle(3);
    cyc(); drive(1, 1, 2, 2'b11, 9, 1, 0, 1); push_exp("t5_flushed", 0, 4'h0, RF, 2, 1);
    cyc(); drive(1, 9, 9, 2'b11, 15, 1, 0, 0); mem_alu_data = 32'hA5;
    push_exp("t5_cons", 0, 4'h0, RF, 2, 1);
    cyc(); drive(0, 0, 0, 2'b00, 0, 0, 0, 0); mem_alu_data = 32'hA5; wb_data = 32'h99;
    push_exp("t5_nofwd", 0, 4'h0, RF, 2, 1);
    idle(3);

    // Reset asserted during a stall cycle.
    cyc(); drive(1, 1, 2, 2'b11, 7, 1, 1, 0);
    cyc(); drive(1, 7, 7, 2'b11, 9, 1, 0, 0); push_exp("t6_rst", 0, 4'h0, RF, 0, 1);
    #1 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    cyc(); drive(1, 7, 7, 2'b11, 9, 1, 0, 0); push_exp("t6_after", 0, 4'h0, RF, 0, 1);
    cyc(); drive(0, 0, 0, 2'b00, 0, 0, 0, 0); push_exp("t6_ex", 0, 4'h0, RF, 0, 1);
    idle(3);

    // Self-dependent loads stall every other cycle: 19 stalls saturate a 4-bit counter.
    for (int i = 1; i <= 38; i++) begin
      cyc();
      drive(1, 7, 7, 2'b01, 7, 1, 1, 0);
      if (i == 2)  push_exp("t7_first", 1, 4'h0, RF, 0, 0);
      if (i == 29) push_exp("t7_c14", 0, 4'h0, RF, 14, 0);
      if (i == 30) push_exp("t7_s15", 1, 4'h0, RF, 14, 0);
      if (i == 31) push_exp("t7_c15", 0, 4'h0, RF, 15, 0);
      if (i == 38) push_exp("t7_sat", 1, 4'h0, RF, 15, 0);
    end
    cyc(); drive(0, 0, 0, 2'b00, 0, 0, 0, 0); push_exp("t7_end", 0, 4'h0, RF, 15, 1);

    @(negedge clk);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
